warp_scheduler: RTL and testbench
=================================

// Module: warp_scheduler
// PURPOSE
//  Multi-warp issue controller in front of the SM core's fetch/decode path. Holds one PC and one
//  state per warp, selects one READY warp per cycle round-robin, drives the instruction-memory
//  address for it, and updates that warp's PC/state from decode feedback (next, branch, memory
//  wait, halt). Memory completions wake waiting warps.
// PARAMETERS
//  NUM_WARPS        4                     number of resident warps (power of 2, >=2)
//  WARP_ID_W        2                     log2(NUM_WARPS)
//  ADDR_W           `INSTMEM_ADDR_WIDTH   PC / instruction-address width
// PORTS
//  clk            in   1          clock, all state on rising edge
//  reset          in   1          synchronous, active-high
//  start          in   1          launch all warps at start_pc (accepted only when not busy)
//  start_pc       in   ADDR_W     initial PC for every warp
//  issue_valid    out  1          a warp is selected this cycle
//  issue_warp     out  WARP_ID_W  selected warp id
//  inst_addr      out  ADDR_W     PC of selected warp, to instruction memory
//  issue_ready    in   1          core accepts the issue this cycle
//  ctrl_valid     in   1          decode feedback valid
//  ctrl_warp      in   WARP_ID_W  warp the feedback belongs to
//  ctrl_kind      in   2          `CTRL_NEXT / `CTRL_BRANCH / `CTRL_WAIT_MEM / `CTRL_HALT
//  ctrl_target    in   ADDR_W     branch target (from I field), used only for CTRL_BRANCH
//  mem_done_valid in   1          memory op completed
//  mem_done_warp  in   WARP_ID_W  warp whose memory op completed
//  busy           out  1          any warp not IDLE/DONE
//  done           out  1          all warps DONE (level, held until next start or reset)
//  proto_err      out  1          sticky: illegal feedback/completion received
// BEHAVIOUR
//  - Per-warp states: IDLE, READY, INFLIGHT, WAIT_MEM, DONE. Reset: all IDLE, all PCs 0,
//    rr pointer = NUM_WARPS-1 (warp 0 wins first), busy=done=proto_err=issue_valid=0.
//  - start && !busy: every warp -> READY, PC <= start_pc, done <= 0, proto_err kept. start while
//    busy ignored.
//  - Issue (combinational from registers): issue_valid = any warp READY; issue_warp = first READY
//    warp after rr pointer (circular); inst_addr = PC[issue_warp]; zero when !issue_valid.
//  - issue_valid && issue_ready: warp -> INFLIGHT, rr pointer <= issue_warp. No handshake -> no
//    state change, same selection held next cycle unless a higher-priority warp became READY.
//  - ctrl_valid for an INFLIGHT warp: NEXT -> PC+1, READY; BRANCH -> PC=ctrl_target, READY;
//    WAIT_MEM -> PC+1, WAIT_MEM; HALT -> DONE (PC unchanged). PC+1 wraps modulo 2^ADDR_W.
//  - ctrl_valid for a warp not INFLIGHT: ignored, proto_err <= 1.
//  - mem_done_valid for a WAIT_MEM warp -> READY; otherwise ignored, proto_err <= 1.
//  - A warp made READY in cycle t is first eligible for issue in cycle t+1 (no bypass).
//  - Same cycle: issue, ctrl and mem_done each target distinct warps normally; all apply.
//    ctrl/mem_done to the warp being issued is illegal (it is READY) -> proto_err, issue wins.
//  - done = all warps DONE (registered, asserted the cycle after the last HALT); busy = !done
//    && any warp not IDLE.
//  - reset at any time, incl. mid-operation, returns to reset state next edge; in-flight
//    feedback after reset is treated as illegal (proto_err).
// STRUCTURE
//  - constants.v: WARP_IDLE/READY/INFLIGHT/WAIT_MEM/DONE (3-bit), CTRL_NEXT=0, CTRL_BRANCH=1,
//    CTRL_WAIT_MEM=2, CTRL_HALT=3.
//  - Sub-module rr_arbiter (req[NUM_WARPS], last ptr -> grant id + valid), combinational.
//  - PC array and state array held in warp_scheduler; no per-warp instance of pc.
// TESTING
//  1. reset, start=1 start_pc=0x10 -> next cycles issue warps 0,1,2,3 at inst_addr 0x10 with
//     issue_ready=1 and NEXT feedback 1 cycle later; second round addresses 0x11.
//  2. issue_ready=0 for 3 cycles -> issue_warp/inst_addr stable, no state change.
//  3. warp1 BRANCH target 0x3F -> warp1's next issue inst_addr=0x3F; PC 0xFF + NEXT -> 0x00.
//  4. warp2 WAIT_MEM -> warp2 skipped by arbiter until mem_done_warp=2, eligible cycle after.
//  5. HALT all four warps -> done=1 one cycle after last HALT, busy=0; start relaunches, done=0.
//  6. ctrl for IDLE warp and mem_done for READY warp -> proto_err=1 sticky; start while busy
//     ignored; reset mid-run -> all outputs 0, warp 0 first after next start.

Source files
------------

// File: rtl/warp_scheduler_pkg.sv
// Shared constants for the warp scheduler.
//   INSTMEM_ADDR_WIDTH : default PC / instruction-address width
//   WARP_*             : 3-bit per-warp state encodings
//   CTRL_*             : 2-bit decode feedback kinds
package warp_scheduler_pkg;

  localparam int INSTMEM_ADDR_WIDTH = 8;

  localparam logic [2:0] WARP_IDLE     = 3'd0;
  localparam logic [2:0] WARP_READY    = 3'd1;
  localparam logic [2:0] WARP_INFLIGHT = 3'd2;
  localparam logic [2:0] WARP_WAIT_MEM = 3'd3;
  localparam logic [2:0] WARP_DONE     = 3'd4;

  localparam logic [1:0] CTRL_NEXT     = 2'd0;
  localparam logic [1:0] CTRL_BRANCH   = 2'd1;
  localparam logic [1:0] CTRL_WAIT_MEM = 2'd2;
  localparam logic [1:0] CTRL_HALT     = 2'd3;

endpackage

// File: rtl/warp_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : one request bit per warp
//   last  : id of the most recently granted warp (search starts just after it)
//   grant : first requesting id after last, circularly (0 when nothing requested)
//   valid : at least one request present
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic [ID_W-1:0] grant,
  output logic            valid
);

  logic [ID_W-1:0] idx;

  // Walk the offsets from farthest to nearest so the nearest requester
  // after 'last' is the one left in grant. N is a power of two, so
  // truncating to ID_W bits gives the circular wrap.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      idx = ID_W'(32'(last) + k);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Multi-warp issue controller: one PC and state per warp, round-robin issue
// of READY warps, PC/state update from decode feedback, memory-done wakeup.
//   clk, reset                       : clock, synchronous active-high reset
//   start, start_pc                  : launch all warps (ignored while busy)
//   issue_valid/issue_warp/inst_addr : selected warp and its PC
//   issue_ready                      : core accepts the issue
//   ctrl_valid/ctrl_warp/ctrl_kind/ctrl_target : decode feedback
//   mem_done_valid/mem_done_warp     : memory completion
//   busy, done, proto_err            : status (proto_err sticky)
module warp_scheduler
  import warp_scheduler_pkg::*;
#(
  parameter int NUM_WARPS = 4,
  parameter int WARP_ID_W = 2,
  parameter int ADDR_W    = INSTMEM_ADDR_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    start_pc,
  output logic                 issue_valid,
  output logic [WARP_ID_W-1:0] issue_warp,
  output logic [ADDR_W-1:0]    inst_addr,
  input  logic                 issue_ready,
  input  logic                 ctrl_valid,
  input  logic [WARP_ID_W-1:0] ctrl_warp,
  input  logic [1:0]           ctrl_kind,
  input  logic [ADDR_W-1:0]    ctrl_target,
  input  logic                 mem_done_valid,
  input  logic [WARP_ID_W-1:0] mem_done_warp,
  output logic                 busy,
  output logic                 done,
  output logic                 proto_err
);

  logic [2:0]           state_reg [NUM_WARPS];
  logic [2:0]           state_next[NUM_WARPS];
  logic [ADDR_W-1:0]    pc_reg    [NUM_WARPS];
  logic [ADDR_W-1:0]    pc_next   [NUM_WARPS];
  logic [WARP_ID_W-1:0] rr_reg;
  logic                 done_reg;
  logic                 proto_err_reg;

  logic [NUM_WARPS-1:0] ready_vec;
  logic [NUM_WARPS-1:0] not_idle_vec;
  logic                 all_done_next;
  logic                 start_accept;
  logic                 issue_fire;
  logic                 ctrl_bad;
  logic                 mem_bad;

  always_comb begin
    ready_vec    = '0;
    not_idle_vec = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      ready_vec[i]    = (state_reg[i] == WARP_READY);
      not_idle_vec[i] = (state_reg[i] != WARP_IDLE);
    end
  end

  rr_arbiter #(.N(NUM_WARPS), .ID_W(WARP_ID_W)) u_arb (
    .req   (ready_vec),
    .last  (rr_reg),
    .grant (issue_warp),
    .valid (issue_valid)
  );

  assign inst_addr    = issue_valid ? pc_reg[issue_warp] : '0;
  assign busy         = !done_reg && (|not_idle_vec);
  assign done         = done_reg;
  assign proto_err    = proto_err_reg;
  assign start_accept = start && !busy;
  assign issue_fire   = issue_valid && issue_ready;

  // A warp being issued this cycle is READY, so feedback aimed at it is
  // already flagged here and cannot disturb the issue.
  assign ctrl_bad = ctrl_valid && (state_reg[ctrl_warp] != WARP_INFLIGHT);
  assign mem_bad  = mem_done_valid && (state_reg[mem_done_warp] != WARP_WAIT_MEM);

  always_comb begin
    all_done_next = 1'b1;
    for (int i = 0; i < NUM_WARPS; i++) begin
      state_next[i] = state_reg[i];
      pc_next[i]    = pc_reg[i];
      if (start_accept) begin
        state_next[i] = WARP_READY;
        pc_next[i]    = start_pc;
      end else if (issue_fire && issue_warp == WARP_ID_W'(i)) begin
        state_next[i] = WARP_INFLIGHT;
      end else if (ctrl_valid && ctrl_warp == WARP_ID_W'(i)
                   && state_reg[i] == WARP_INFLIGHT) begin
        case (ctrl_kind)
          CTRL_NEXT: begin
            state_next[i] = WARP_READY;
            pc_next[i]    = pc_reg[i] + 1'b1;
          end
          CTRL_BRANCH: begin
            state_next[i] = WARP_READY;
            pc_next[i]    = ctrl_target;
          end
          CTRL_WAIT_MEM: begin
            state_next[i] = WARP_WAIT_MEM;
            pc_next[i]    = pc_reg[i] + 1'b1;
          end
          default: state_next[i] = WARP_DONE;
        endcase
      end else if (mem_done_valid && mem_done_warp == WARP_ID_W'(i)
                   && state_reg[i] == WARP_WAIT_MEM) begin
        state_next[i] = WARP_READY;
      end
      if (state_next[i] != WARP_DONE) all_done_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        state_reg[i] <= WARP_IDLE;
        pc_reg[i]    <= '0;
      end
      rr_reg        <= WARP_ID_W'(NUM_WARPS - 1);
      done_reg      <= 1'b0;
      proto_err_reg <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        state_reg[i] <= state_next[i];
        pc_reg[i]    <= pc_next[i];
      end
      if (issue_fire) rr_reg <= issue_warp;
      // Registered from next state so done rises the cycle after the last HALT.
      done_reg <= all_done_next;
      if (ctrl_bad || mem_bad) proto_err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_warp_scheduler.sv
module tb_warp_scheduler;
  import warp_scheduler_pkg::*;

  localparam int NW = 4;
  localparam int IW = 2;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic          issue_valid;
  logic [IW-1:0] issue_warp;
  logic [AW-1:0] inst_addr;
  logic          issue_ready = 1'b0;
  logic          ctrl_valid = 1'b0;
  logic [IW-1:0] ctrl_warp = '0;
  logic [1:0]    ctrl_kind = '0;
  logic [AW-1:0] ctrl_target = '0;
  logic          mem_done_valid = 1'b0;
  logic [IW-1:0] mem_done_warp = '0;
  logic          busy;
  logic          done;
  logic          proto_err;

  int checks = 0;
  int errors = 0;

  warp_scheduler #(.NUM_WARPS(NW), .WARP_ID_W(IW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .issue_valid(issue_valid), .issue_warp(issue_warp), .inst_addr(inst_addr),
    .issue_ready(issue_ready), .ctrl_valid(ctrl_valid), .ctrl_warp(ctrl_warp),
    .ctrl_kind(ctrl_kind), .ctrl_target(ctrl_target),
    .mem_done_valid(mem_done_valid), .mem_done_warp(mem_done_warp),
    .busy(busy), .done(done), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_issue(input string tag, input logic [IW-1:0] w, input logic [AW-1:0] a);
    chk({tag, "_valid"}, 32'(issue_valid), 32'd1);
    chk({tag, "_warp"}, 32'(issue_warp), 32'(w));
    chk({tag, "_addr"}, 32'(inst_addr), 32'(a));
  endtask

  // Check the offered warp, accept it for exactly one cycle.
  task automatic issue_one(input string tag, input logic [IW-1:0] w, input logic [AW-1:0] a);
    chk_issue(tag, w, a);
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
  endtask

  task automatic fb(input logic [IW-1:0] w, input logic [1:0] k, input logic [AW-1:0] t);
    ctrl_valid = 1'b1; ctrl_warp = w; ctrl_kind = k; ctrl_target = t;
    step();
    ctrl_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    step(); step();
    reset = 1'b0;
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_inst_addr", 32'(inst_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);

    // 1. Launch and pipelined round-robin with NEXT feedback one cycle later
    start = 1'b1; start_pc = 8'h10;
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    issue_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk_issue($sformatf("rr%0d", i), IW'(i % 4), AW'(8'h10 + i / 4));
      if (i > 0) begin
        ctrl_valid = 1'b1; ctrl_warp = IW'((i - 1) % 4); ctrl_kind = CTRL_NEXT;
      end
      step();
    end
    issue_ready = 1'b0;
    ctrl_valid = 1'b1; ctrl_warp = 2'd3; ctrl_kind = CTRL_NEXT;
    step();
    ctrl_valid = 1'b0;

    // 2. Stall: selection held, nothing changes
    for (int i = 0; i < 3; i++) begin
      chk_issue($sformatf("stall%0d", i), 2'd0, 8'h12);
      step();
    end

    // 3. Branch and PC wrap
    issue_one("b0", 2'd0, 8'h12);
    issue_one("b1", 2'd1, 8'h12);
    fb(2'd1, CTRL_BRANCH, 8'h3F);
    fb(2'd0, CTRL_NEXT, 8'h00);
    issue_one("b2", 2'd2, 8'h12);
    issue_one("b3", 2'd3, 8'h12);
    issue_one("b4", 2'd0, 8'h13);
    issue_one("br_target", 2'd1, 8'h3F);
    fb(2'd1, CTRL_BRANCH, 8'hFF);
    issue_one("pc_ff", 2'd1, 8'hFF);
    fb(2'd1, CTRL_NEXT, 8'h00);
    issue_one("pc_wrap", 2'd1, 8'h00);
    fb(2'd0, CTRL_NEXT, 8'h00);
    fb(2'd2, CTRL_NEXT, 8'h00);
    fb(2'd3, CTRL_NEXT, 8'h00);
    fb(2'd1, CTRL_NEXT, 8'h00);

    // 4. WAIT_MEM: warp 2 parked until mem_done, eligible the cycle after
    issue_one("m2", 2'd2, 8'h13);
    fb(2'd2, CTRL_WAIT_MEM, 8'h00);
    issue_one("m_skip3", 2'd3, 8'h13);
    issue_one("m_0", 2'd0, 8'h14);
    issue_one("m_1", 2'd1, 8'h01);
    chk("wait_no_issue", 32'(issue_valid), 32'd0);
    chk("wait_addr_zero", 32'(inst_addr), 32'd0);
    mem_done_valid = 1'b1; mem_done_warp = 2'd2;
    chk("memdone_no_bypass", 32'(issue_valid), 32'd0);
    step();
    mem_done_valid = 1'b0;
    chk("memdone_err", 32'(proto_err), 32'd0);

    // 5. HALT everything
    issue_one("wake2", 2'd2, 8'h14);
    fb(2'd0, CTRL_HALT, 8'h00);
    fb(2'd1, CTRL_HALT, 8'h00);
    fb(2'd3, CTRL_HALT, 8'h00);
    chk("pre_done", 32'(done), 32'd0);
    chk("pre_busy", 32'(busy), 32'd1);
    ctrl_valid = 1'b1; ctrl_warp = 2'd2; ctrl_kind = CTRL_HALT;
    chk("halt_cycle_done", 32'(done), 32'd0);
    step();
    ctrl_valid = 1'b0;
    chk("done", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_no_issue", 32'(issue_valid), 32'd0);
    step();
    chk("done_held", 32'(done), 32'd1);
    start = 1'b1; start_pc = 8'h20;
    step();
    start = 1'b0;
    chk("relaunch_done", 32'(done), 32'd0);
    chk("relaunch_busy", 32'(busy), 32'd1);
    chk_issue("relaunch", 2'd3, 8'h20);
    chk("err_clean", 32'(proto_err), 32'd0);

    // 6. Protocol errors, start while busy, reset mid-run
    mem_done_valid = 1'b1; mem_done_warp = 2'd1;
    step();
    mem_done_valid = 1'b0;
    chk("err_memdone_ready", 32'(proto_err), 32'd1);
    start = 1'b1; start_pc = 8'h50;
    step();
    start = 1'b0;
    chk_issue("start_ignored", 2'd3, 8'h20);
    chk("err_sticky", 32'(proto_err), 32'd1);
    issue_one("midrun", 2'd3, 8'h20);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst2_issue_warp", 32'(issue_warp), 32'd0);
    chk("rst2_inst_addr", 32'(inst_addr), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_done", 32'(done), 32'd0);
    chk("rst2_proto_err", 32'(proto_err), 32'd0);
    fb(2'd3, CTRL_NEXT, 8'h00);
    chk("err_ctrl_idle", 32'(proto_err), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    start = 1'b1; start_pc = 8'h30;
    step();
    start = 1'b0;
    chk_issue("after_rst", 2'd0, 8'h30);
    chk("err_kept", 32'(proto_err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
